resp_fifo_sync: RTL
===================

Name: resp_fifo_sync

Overview:
- Parametrised single-clock response FIFO; next generation of the bridge's 2-bit response buffer.
- Used where AXI and AHB sides share one clock.
- Generalised data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Sits between the AHB response capture and the AXI B/R response channel drivers.

Parameters:
- DATA_WIDTH, 2, width of each entry (2 = AXI/AHB resp code).
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16).
- AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data.
- write_en  input  1  write request.
- read_en  input  1  read request.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (unless AFULL_THRESH config makes it 1; not legal), overflow = 0, underflow = 0, data_out = 0.
- Storage array is not reset.
- Pointers are ADDR_WIDTH+1 bits, binary, and wrap naturally. Storage is indexed by ptr[ADDR_WIDTH-1:0].
- wr_accept = write_en & ~full, using full as registered at the start of the cycle. There is no write-through-when-full, even if a read is accepted the same cycle.
- rd_accept = read_en & ~empty, using empty as registered at the start of the cycle. A write to an empty FIFO is not readable the same cycle.
- On wr_accept: mem[wr_ptr] <= data_in; wr_ptr increments by 1.
- On rd_accept: rd_ptr increments by 1.
- Count update:
  - count +1 on wr_accept only.
  - count -1 on rd_accept only.
  - count unchanged when both accept or neither accepts.
- full, empty, almost_full and almost_empty are registered. Each is derived from the next count value, so it is valid in the same cycle count updates.
- Default read timing (combinational): data_out = mem[rd_ptr] when read_en & ~empty, else 0. Data is presented in the same cycle as the accepted read.
- overflow sets on write_en & full. underflow sets on read_en & empty. Both hold until reset.
- Rejected accesses leave pointers, count and memory untouched.
- Wrap-around: after DEPTH writes and DEPTH reads, pointers return to index 0 with MSB toggled. full/empty remain correct across any number of wraps.
- Reset mid-operation: contents are discarded, so the FIFO reads empty on the next cycle. Any read or write presented in the reset cycle is ignored.

Optional Feature:
- Macro: RESP_FIFO_OUT_REG_EN.
- When defined, data_out is a register:
  - On rd_accept, data_out <= mem[rd_ptr] at the clock edge, so data is valid one cycle after the accepted read.
  - data_out holds its value when no read is accepted.
  - Adds output port data_valid (1 bit, reset 0), which is high for exactly one cycle following each rd_accept.
- When not defined: combinational output as in Behaviour, and no data_valid port.

Test Plan:
- Reset, then write 2'b01,2'b10,2'b11 (one per cycle), then read 3 -> data_out 01,10,11 in order; count goes 1,2,3, then 2,1,0; empty returns to 1 after the third read.
- Write 16 entries with no reads -> full = 1 after the 16th write and count = 16; almost_full first asserts at count = 12. A 17th write sets overflow = 1 and leaves count = 16 and contents unchanged.
- Read from an empty FIFO -> data_out = 0, underflow = 1, count stays 0. Then apply reset -> underflow returns to 0.
- Hold count at 8, assert write_en and read_en together for 40 cycles with an incrementing pattern -> count stays 8, data is in order across pointer wraps, and full/empty never toggle.
- Fill to 5 entries, assert reset for one cycle together with write_en=1 -> the cycle after, count = 0, empty = 1 and almost_empty = 1; the next write is read back as the first entry.
- With RESP_FIFO_OUT_REG_EN defined: write 2'b10 then read -> data_out = 10 and data_valid = 1 on the cycle after the read; data_out holds 10 afterwards with data_valid = 0.

Source files
------------

// File: rtl/resp_fifo_sync.sv
// Single-clock response FIFO with occupancy count, almost-full/almost-empty flags and sticky error flags.
// Define RESP_FIFO_OUT_REG_EN to register data_out and add the data_valid port.
module resp_fifo_sync #(
    parameter int DATA_WIDTH    = 2,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef RESP_FIFO_OUT_REG_EN
    ,
    output logic                  data_valid
`endif
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_accept;
    logic                  rd_accept;

    // Handshake: write_en/read_en are the requests; ~full/~empty, as registered at
    // the start of the cycle, are the grants. A transfer happens only when both are
    // high at the rising edge; a refused request changes nothing but the sticky flags.
    assign wr_accept = write_en & ~full;
    assign rd_accept = read_en & ~empty;
    assign rd_data   = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + ONE_C;
            2'b01:   count_next = count - ONE_C;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AFULL_THRESH <= 0);
            almost_empty <= (AEMPTY_THRESH >= 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + ONE_C;
            if (rd_accept) rd_ptr <= rd_ptr + ONE_C;
            count        <= count_next;
            // Flags follow the next count so they line up with count itself.
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            overflow     <= overflow | (write_en & full);
            underflow    <= underflow | (read_en & empty);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !reset) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end

`ifdef RESP_FIFO_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_accept;
            if (rd_accept) data_out <= rd_data;
        end
    end
`else
    assign data_out = rd_accept ? rd_data : '0;
`endif

endmodule
